downconverter_model: RTL and testbench

- Receive-side counterpart of the fs/4 1-bit upconverter: takes the single-bit mixed stream and recovers baseband I and Q.
- Rotation per 4-cycle frame, phases p0..p3: I, ~Q, ~I, Q.
- Each recovered bit is mapped to ±1 and integrated over DECIM frames (integrate-and-dump).
- Emits signed I/Q samples with a one-cycle valid strobe. Used in loopback benches and as the behavioural receiver in the DAC test path.

---
 rtl/downconverter_pkg.sv | 10 +
 rtl/downconverter_model_integrate_dump.sv | 27 ++
 rtl/downconverter_model.sv | 56 +++++
 tb/tb_downconverter_model.sv | 136 +++++++++++++
 4 files changed

// File: rtl/downconverter_pkg.sv
// downconverter_pkg: shared phase type and arithmetic helpers for the fs/4 downconverter
package downconverter_pkg;
  typedef enum logic [1:0] {PH_I, PH_NQ, PH_NI, PH_Q} phase_t;
  function automatic logic signed [1:0] bit_to_pm1(input logic b);
    return b ? 2'sb01 : 2'sb11;
  endfunction
  function automatic int out_w(input int decim);
    return $clog2(2 * decim + 1) + 1;
  endfunction
endpackage

// File: rtl/downconverter_model_integrate_dump.sv
// integrate_dump: signed ±1 integrator that can restart on the current bit or clear to zero
module integrate_dump
  import downconverter_pkg::*;
#(
  parameter int DECIM = 16,
  parameter int W = out_w(DECIM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                din,
  input  logic                clear,
  input  logic                dump,
  output logic signed [W-1:0] sum,
  output logic signed [W-1:0] nxt
);
  logic signed [1:0] pm;
  logic signed [W-1:0] inc;
  assign pm = bit_to_pm1(din);
  // this cycle's contribution, sign-extended to the accumulator width
  always_comb inc = en ? {{(W-2){pm[1]}}, pm} : '0;
  assign nxt = sum + inc;
  // dump zeroes, clear restarts from this bit alone, otherwise integrate
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else sum <= dump ? '0 : clear ? inc : nxt;
endmodule

// File: rtl/downconverter_model.sv
// downconverter_model: fs/4 1-bit downconverter with integrate-and-dump I/Q recovery
module downconverter_model
  import downconverter_pkg::*;
#(
  parameter int DECIM = 16,
  localparam int OUT_W = out_w(DECIM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync_in,
  input  logic                    data_in,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    valid_out,
  output logic [1:0]              frame_phase
);
  localparam int CW = $clog2(DECIM + 1);
  phase_t phase, eff;
  logic [CW-1:0] frame_cnt;
  logic b, en_i, en_q, dump;
  logic signed [OUT_W-1:0] i_sum, i_nxt, q_sum, q_nxt;
  // sync forces the sampled bit to p0; p1/p2 bits arrive inverted
  always_comb begin
    eff = sync_in ? PH_I : phase;
    b = data_in ^ (eff == PH_NQ || eff == PH_NI);
    en_i = eff == PH_I || eff == PH_NI;
    en_q = !en_i;
    dump = eff == PH_Q && frame_cnt == CW'(DECIM - 1);
  end
  assign frame_phase = eff;
  integrate_dump #(.DECIM(DECIM), .W(OUT_W)) u_i (
    .clk(clk), .rst(rst), .en(en_i), .din(b), .clear(sync_in), .dump(dump),
    .sum(i_sum), .nxt(i_nxt)
  );
  integrate_dump #(.DECIM(DECIM), .W(OUT_W)) u_q (
    .clk(clk), .rst(rst), .en(en_q), .din(b), .clear(sync_in), .dump(dump),
    .sum(q_sum), .nxt(q_nxt)
  );
  // phase/frame counters, output registers and the one-cycle valid strobe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase <= PH_I;
      frame_cnt <= '0;
      i_out <= '0;
      q_out <= '0;
      valid_out <= 1'b0;
    end else begin
      phase <= phase_t'(eff + 2'd1);
      frame_cnt <= (sync_in || dump) ? '0 : eff == PH_Q ? frame_cnt + CW'(1) : frame_cnt;
      valid_out <= dump;
      if (dump) begin
        i_out <= en_i ? i_nxt : i_sum;
        q_out <= en_q ? q_nxt : q_sum;
      end
    end
endmodule

// File: tb/tb_downconverter_model.sv
// tb_downconverter_model: table, corner-case and random checks of DECIM=4 and DECIM=1 instances
module tb_downconverter_model;
  logic clk = 0, rst = 1, sync_in = 0, data_in = 0;
  logic signed [4:0] i4, q4;
  logic signed [2:0] i1, q1;
  logic v4, v1;
  logic [1:0] fp4, fp1, fp_pre;
  int tests = 0, fails = 0, nv4 = 0, nv1 = 0;
  int dec[2] = '{4, 1};
  int pos[2], si[2], sq[2], ei[2], eq[2];
  bit ev[2];
  typedef struct {logic [3:0] pat; int ei4, eq4, ei1, eq1;} vec_t;
  vec_t tbl[5];
  logic [3:0] p;

  downconverter_model #(.DECIM(4)) dut4 (
    .clk(clk), .rst(rst), .sync_in(sync_in), .data_in(data_in),
    .i_out(i4), .q_out(q4), .valid_out(v4), .frame_phase(fp4)
  );
  downconverter_model #(.DECIM(1)) dut1 (
    .clk(clk), .rst(rst), .sync_in(sync_in), .data_in(data_in),
    .i_out(i1), .q_out(q1), .valid_out(v1), .frame_phase(fp1)
  );

  always #5 clk = ~clk;

  function void cmp(string n, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction

  function void m_reset();
    for (int k = 0; k < 2; k++) begin
      pos[k] = 0; si[k] = 0; sq[k] = 0; ei[k] = 0; eq[k] = 0; ev[k] = 0;
    end
  endfunction

  function void m_clk(input logic s, input logic d);
    for (int k = 0; k < 2; k++) begin
      int ph, v;
      if (s) begin pos[k] = 0; si[k] = 0; sq[k] = 0; end
      ph = pos[k] % 4;
      v = (((ph == 1 || ph == 2) ? !d : d) ? 1 : -1);
      if (ph % 2 == 0) si[k] += v; else sq[k] += v;
      pos[k]++;
      ev[k] = 0;
      if (pos[k] == 4 * dec[k]) begin
        ei[k] = si[k]; eq[k] = sq[k]; ev[k] = 1;
        pos[k] = 0; si[k] = 0; sq[k] = 0;
      end
    end
  endfunction

  function void check();
    cmp("valid4", v4, ev[0]);
    cmp("i4", i4, ei[0]);
    cmp("q4", q4, eq[0]);
    cmp("fp4", fp4, sync_in ? 0 : pos[0] % 4);
    cmp("valid1", v1, ev[1]);
    cmp("i1", i1, ei[1]);
    cmp("q1", q1, eq[1]);
    cmp("fp1", fp1, sync_in ? 0 : pos[1] % 4);
  endfunction

  task step(input logic r, input logic s, input logic d);
    rst = r; sync_in = s; data_in = d;
    #1;
    if (r) m_reset();
    check();
    fp_pre = fp4;
    @(posedge clk);
    if (!r) m_clk(s, d);
    #1;
    check();
    if (v4) nv4++;
    if (v1) nv1++;
  endtask

  initial begin
    tbl = '{'{4'b1001, 8, 8, 2, 2}, '{4'b1010, 0, 0, 0, 0}, '{4'b0110, -8, -8, -2, -2},
            '{4'b1100, 8, -8, 2, -2}, '{4'b0011, -8, 8, -2, 2}};
    m_reset();
    repeat (2) step(1, 0, 0);
    cmp("rst_i4", i4, 0);
    cmp("rst_v4", v4, 0);
    for (int t = 0; t < 5; t++) begin
      p = tbl[t].pat;
      nv4 = 0; nv1 = 0;
      for (int k = 0; k < 32; k++) step(0, k == 0, p[3 - k % 4]);
      cmp("tbl_i4", i4, tbl[t].ei4);
      cmp("tbl_q4", q4, tbl[t].eq4);
      cmp("tbl_i1", i1, tbl[t].ei1);
      cmp("tbl_q1", q1, tbl[t].eq1);
      cmp("tbl_nv4", nv4, 2);
      cmp("tbl_nv1", nv1, 8);
    end
    nv4 = 0;
    for (int k = 0; k < 128; k++) step(0, k == 0, k < 64);
    cmp("dc_i4", i4, 0);
    cmp("dc_q4", q4, 0);
    cmp("dc_nv4", nv4, 8);
    p = 4'b1001;
    for (int k = 0; k < 7; k++) step(0, k == 0, p[3 - k % 4]);
    step(0, 1, 1);
    cmp("sync_fp", fp_pre, 0);
    nv4 = 0;
    for (int k = 1; k < 15; k++) step(0, 0, p[3 - k % 4]);
    cmp("sync_novalid", nv4, 0);
    step(0, 0, p[0]);
    cmp("sync_v4", v4, 1);
    cmp("sync_i4", i4, 8);
    cmp("sync_q4", q4, 8);
    p = 4'b0110;
    for (int k = 0; k < 10; k++) step(0, k == 0, p[3 - k % 4]);
    repeat (3) begin
      step(1, 0, 1'($urandom_range(0, 1)));
      cmp("rstmid_i4", i4, 0);
      cmp("rstmid_q4", q4, 0);
      cmp("rstmid_v4", v4, 0);
    end
    nv4 = 0;
    for (int k = 0; k < 15; k++) step(0, 0, p[3 - k % 4]);
    cmp("rstmid_novalid", nv4, 0);
    step(0, 0, p[0]);
    cmp("rstmid_v", v4, 1);
    cmp("rstmid_wi4", i4, -8);
    cmp("rstmid_wq4", q4, -8);
    repeat (1500)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
